// File: rtl/fp_sub_seq.sv
// fp_sub_seq
//   Multi-cycle IEEE-754 single-precision subtractor (result = a - b) for the
//   FP functional unit. One operation in flight, truncating rounding,
//   denormal inputs and underflowing results flushed to signed zero,
//   normalization shifts left one bit per cycle.
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake (in_ready high only in IDLE)
//   a, b, in_tag          minuend, subtrahend, reservation-station tag
//   out_valid/out_ready   result handshake toward the CDB arbiter
//   result, out_tag       a - b and the tag captured at accept
module fp_sub_seq #(
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      a,
   input  logic [31:0]      b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      result,
   output logic [TAG_W-1:0] out_tag
);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_e;

   state_e           state_q;
   logic [31:0]      a_q, b_q;
   logic [TAG_W-1:0] tag_q;
   logic             sign_q, sub_q, special_q;
   logic [7:0]       exp_q;
   logic [23:0]      mbig_q, msml_q;
   logic [24:0]      sum_q;
   logic [31:0]      result_q;
   logic             out_valid_q, in_ready_q;

   // Unpack / classify / align, evaluated on the captured operands.
   logic        sa, sb, za, zb, nan, inf_a, inf_b, a_big;
   logic [7:0]  ea, eb, diff;
   logic [22:0] fa, fb;
   logic [23:0] ma, mb, msml_raw;
   logic        special_d, sign_d, sub_d;
   logic [31:0] spec_res_d;
   logic [7:0]  exp_d;
   logic [23:0] mbig_d, msml_d;

   always_comb begin
      sa    = a_q[31];
      sb    = ~b_q[31];                  // a - b == a + (-b)
      ea    = a_q[30:23];
      eb    = b_q[30:23];
      fa    = a_q[22:0];
      fb    = b_q[22:0];
      nan   = (ea == 8'hFF && fa != '0) || (eb == 8'hFF && fb != '0);
      inf_a = (ea == 8'hFF) && (fa == '0);
      inf_b = (eb == 8'hFF) && (fb == '0);
      za    = (ea == '0);
      zb    = (eb == '0);
      ma    = za ? '0 : {1'b1, fa};
      mb    = zb ? '0 : {1'b1, fb};
      a_big = {ea, ma} >= {eb, mb};

      special_d  = 1'b1;
      spec_res_d = '0;
      if (nan)
         spec_res_d = QNAN;
      else if (inf_a && inf_b)
         spec_res_d = (sa != sb) ? QNAN : {sa, 8'hFF, 23'd0};
      else if (inf_a)
         spec_res_d = {sa, 8'hFF, 23'd0};
      else if (inf_b)
         spec_res_d = {sb, 8'hFF, 23'd0};
      else if (za && zb)
         spec_res_d = {sa & sb, 31'd0};
      else
         special_d = 1'b0;

      diff     = a_big ? (ea - eb) : (eb - ea);
      msml_raw = a_big ? mb : ma;
      msml_d   = (diff >= 8'd25) ? '0 : (msml_raw >> diff);
      mbig_d   = a_big ? ma : mb;
      sign_d   = a_big ? sa : sb;
      exp_d    = a_big ? ea : eb;
      sub_d    = sa ^ sb;
   end

   // One normalization decision per cycle on the current sum.
   logic        norm_shift;
   logic [31:0] norm_res_d;

   always_comb begin
      norm_shift = 1'b0;
      norm_res_d = '0;
      if (sum_q == '0)
         norm_res_d = '0;
      else if (sum_q[24])
         norm_res_d = (exp_q == 8'hFE) ? {sign_q, 8'hFF, 23'd0}
                                       : {sign_q, exp_q + 8'd1, sum_q[23:1]};
      else if (sum_q[23])
         norm_res_d = {sign_q, exp_q, sum_q[22:0]};
      else if (exp_q == 8'd1)
         norm_res_d = {sign_q, 31'd0};
      else
         norm_shift = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         tag_q       <= '0;
         sign_q      <= 1'b0;
         sub_q       <= 1'b0;
         special_q   <= 1'b0;
         exp_q       <= '0;
         mbig_q      <= '0;
         msml_q      <= '0;
         sum_q       <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= a;
                  b_q        <= b;
                  tag_q      <= in_tag;
                  in_ready_q <= 1'b0;
                  state_q    <= ALIGN;
               end
            end
            ALIGN: begin
               special_q <= special_d;
               sign_q    <= sign_d;
               sub_q     <= sub_d;
               exp_q     <= exp_d;
               mbig_q    <= mbig_d;
               msml_q    <= msml_d;
               if (special_d)
                  result_q <= spec_res_d;
               state_q   <= ADD;
            end
            // Special results were resolved in ALIGN; they bypass the adder
            // here and skip NORM, giving them a fixed two-cycle latency.
            ADD: begin
               if (special_q) begin
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  sum_q   <= sub_q ? ({1'b0, mbig_q} - {1'b0, msml_q})
                                   : ({1'b0, mbig_q} + {1'b0, msml_q});
                  state_q <= NORM;
               end
            end
            NORM: begin
               if (norm_shift) begin
                  sum_q <= {sum_q[23:0], 1'b0};
                  exp_q <= exp_q - 8'd1;
               end else begin
                  result_q    <= norm_res_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign out_tag   = tag_q;

endmodule

// File: tb/tb_fp_sub_seq.sv
// tb_fp_sub_seq
//   Directed-vector bench for fp_sub_seq: reset state, arithmetic with
//   normalization latency, overflow/underflow/truncation, special operands,
//   DONE stall behaviour, reset during NORM and back-to-back operations.
module tb_fp_sub_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [3:0]  out_tag;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      int          lat;
   } vec_t;

   fp_sub_seq #(.TAG_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   // Stimulus driver: issue one operation, wait (bounded) for out_valid,
   // capture the outputs and complete the output handshake.
   // lat counts rising edges after the accept edge until out_valid is seen.
   task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                        input logic [3:0] tg, output logic [31:0] res,
                        output logic [3:0] otg, output int lat);
      @(negedge clk);
      a = av; b = bv; in_tag = tg; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
      if (lat >= 100) lat = 999;
      res = result;
      otg = out_tag;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++;
      if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", result); end
      checks++;
      if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic run_table(input string name, input vec_t v[]);
      logic [31:0] res;
      logic [3:0]  otg;
      int          lat;
      for (int i = 0; i < v.size(); i++) begin
         do_op(v[i].a, v[i].b, 4'(i + 3), res, otg, lat);
         checks++;
         if (res !== v[i].r) begin
            errors++;
            $display("FAIL %s[%0d]_result %h-%h got %h want %h", name, i, v[i].a, v[i].b, res, v[i].r);
         end
         checks++;
         if (otg !== 4'(i + 3)) begin
            errors++;
            $display("FAIL %s[%0d]_tag got %h want %h", name, i, otg, 4'(i + 3));
         end
         checks++;
         if (lat != v[i].lat) begin
            errors++;
            $display("FAIL %s[%0d]_latency got %0d want %0d", name, i, lat, v[i].lat);
         end
      end
   endtask

   task automatic test_arith;
      vec_t v[];
      v = new[7];
      v[0] = '{32'h40400000, 32'h3F800000, 32'h40000000, 3}; // 3 - 1
      v[1] = '{32'h3F800000, 32'h3F400000, 32'h3E800000, 5}; // 1 - 0.75, 2 shifts
      v[2] = '{32'h40A00000, 32'hC0200000, 32'h40F00000, 3}; // 5 - (-2.5)
      v[3] = '{32'h3F800000, 32'h3F800000, 32'h00000000, 3}; // 1 - 1
      v[4] = '{32'h3F800000, 32'h33800000, 32'h3F800000, 3}; // 1 - 2^-24, shifted out
      v[5] = '{32'h3F800000, 32'h34000000, 32'h3F7FFFFE, 4}; // 1 - 2^-23, truncated
      v[6] = '{32'h3F800000, 32'h00400000, 32'h3F800000, 3}; // denormal b flushed
      run_table("arith", v);
   endtask

   task automatic test_boundary;
      vec_t v[];
      v = new[2];
      v[0] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 3}; // max + max -> +inf
      v[1] = '{32'h00800000, 32'h00800001, 32'h80000000, 3}; // underflow -> -0
      run_table("boundary", v);
   endtask

   task automatic test_special;
      vec_t v[];
      v = new[8];
      v[0] = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 2}; // inf - inf
      v[1] = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 2}; // inf - 1
      v[2] = '{32'h3F800000, 32'h7F800000, 32'hFF800000, 2}; // 1 - inf
      v[3] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2}; // NaN in
      v[4] = '{32'h80000000, 32'h00000000, 32'h80000000, 2}; // -0 - +0
      v[5] = '{32'h00000000, 32'h00000000, 32'h00000000, 2}; // +0 - +0
      v[6] = '{32'h00000001, 32'h80000000, 32'h00000000, 2}; // denorm - (-0)
      v[7] = '{32'h7F800000, 32'hFF800000, 32'h7F800000, 2}; // inf - (-inf)
      run_table("special", v);
   endtask

   task automatic test_stall;
      int n;
      @(negedge clk);
      a = 32'h40400000; b = 32'h3F800000; in_tag = 4'h9; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 100) begin
         @(posedge clk);
         #1 n++;
      end
      checks++;
      if (n >= 100) begin errors++; $display("FAIL stall_timeout got %0d cycles want <100", n); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         a = 32'h3F800000; b = 32'h3F400000; in_tag = 4'h2; in_valid = 1'b1;
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b1 || result !== 32'h40000000 || out_tag !== 4'h9 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d] got v=%b r=%h t=%h rdy=%b want v=1 r=40000000 t=9 rdy=0",
                     i, out_valid, result, out_tag, in_ready);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      end
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_no_extra_op got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] res;
      logic [3:0]  otg;
      int          lat;
      @(negedge clk);
      a = 32'h3F800000; b = 32'h3F400000; in_tag = 4'hC; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);   // now in NORM (first of two shifts)
      #1 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_during got v=%b r=%h want v=0 r=00000000", out_valid, result);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_after got v=%b r=%h rdy=%b want v=0 r=00000000 rdy=1",
                  out_valid, result, in_ready);
      end
      do_op(32'h40A00000, 32'hC0200000, 4'h7, res, otg, lat);
      checks++;
      if (res !== 32'h40F00000 || otg !== 4'h7 || lat != 3) begin
         errors++;
         $display("FAIL rstmid_next got r=%h t=%h lat=%0d want r=40F00000 t=7 lat=3", res, otg, lat);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] res;
      logic [3:0]  otg;
      int          lat;
      do_op(32'h40400000, 32'h3F800000, 4'hA, res, otg, lat);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready got %b want 1", in_ready);
      end
      checks++;
      if (res !== 32'h40000000 || otg !== 4'hA) begin
         errors++;
         $display("FAIL b2b_first got r=%h t=%h want r=40000000 t=a", res, otg);
      end
      do_op(32'h7F800000, 32'h7F800000, 4'hB, res, otg, lat);
      checks++;
      if (res !== 32'h7FC00000 || otg !== 4'hB || lat != 2) begin
         errors++;
         $display("FAIL b2b_second got r=%h t=%h lat=%0d want r=7FC00000 t=b lat=2", res, otg, lat);
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      in_tag = '0;
      test_reset();
      test_arith();
      test_boundary();
      test_special();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
